// File: rtl/superfx_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : superfx_cache_pkg
// Description : Shared definitions for the cache dirty-bit tracker: default
//               tracked block count and the write-back scan state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package superfx_cache_pkg;

   localparam int NUM_BLOCKS_DEFAULT = 32;

   typedef enum logic [1:0] {
      SCAN_IDLE    = 2'd0,
      SCAN_SEARCH  = 2'd1,
      SCAN_PRESENT = 2'd2,
      SCAN_DONE    = 2'd3
   } scan_state_e;

endpackage : superfx_cache_pkg
`default_nettype wire

// File: rtl/dirty_bit_tracker_sel_mux.sv
`default_nettype none
// ============================================================================
// Module      : dirty_sel_mux
// Description : NUM_BLOCKS-to-1 bit selector used to read one dirty bit out
//               of the registered dirty array.
// Revision    : 1.0 - initial release
// ============================================================================
module dirty_sel_mux
   import superfx_cache_pkg::*;
#(
   parameter int NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
   parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
   input  logic [IDX_W-1:0]      sel_i,
   input  logic [NUM_BLOCKS-1:0] data_i,
   output logic                  data_o
);

   // NUM_BLOCKS is a power of two, so every selector value addresses a bit
   assign data_o = data_i[sel_i];

endmodule : dirty_sel_mux
`default_nettype wire

// File: rtl/dirty_bit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : dirty_bit_tracker
// Description : Per-block dirty bit array for a write-back cache, with a
//               single-port query, an any-dirty summary and a sequential
//               write-back scan that presents each dirty block in index
//               order and clears it when the consumer acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module dirty_bit_tracker
   import superfx_cache_pkg::*;
#(
   parameter int NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
   parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_all,
   input  logic             set_en,
   input  logic [IDX_W-1:0] set_index,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_index,
   input  logic [IDX_W-1:0] rd_index,
   output logic             rd_dirty,
   output logic             any_dirty,
   input  logic             scan_start,
   output logic             scan_busy,
   output logic             scan_valid,
   output logic [IDX_W-1:0] scan_index,
   input  logic             scan_ack,
   output logic             scan_done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

   logic [NUM_BLOCKS-1:0] dirty_q;
   logic [NUM_BLOCKS-1:0] dirty_d;
   scan_state_e           state_q;
   scan_state_e           state_d;
   logic [IDX_W-1:0]      ptr_q;
   logic [IDX_W-1:0]      ptr_d;

   logic                  w_ack_fire;
   logic [NUM_BLOCKS-1:0] w_set_vec;
   logic [NUM_BLOCKS-1:0] w_clr_vec;
   logic [NUM_BLOCKS-1:0] w_ack_vec;

   // One-hot decode of each write source into the dirty array
   assign w_set_vec = NUM_BLOCKS'(set_en)     << set_index;
   assign w_clr_vec = NUM_BLOCKS'(clr_en)     << clr_index;
   assign w_ack_vec = NUM_BLOCKS'(w_ack_fire) << ptr_q;

   // Dirty array next state: flush beats scan-ack clear beats set beats clear
   always_comb begin
      dirty_d = ((dirty_q & ~w_clr_vec) | w_set_vec) & ~w_ack_vec;
      if (clear_all) begin
         dirty_d = '0;
      end
   end

   // Scan FSM next state and outputs; ptr doubles as the presented index
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      w_ack_fire = 1'b0;
      scan_valid = 1'b0;
      scan_done  = 1'b0;
      unique case (state_q)
         SCAN_IDLE: begin
            if (scan_start) begin
               ptr_d   = '0;
               state_d = SCAN_SEARCH;
            end
         end
         SCAN_SEARCH: begin
            if (dirty_q[ptr_q]) begin
               state_d = SCAN_PRESENT;
            end else if (ptr_q == LAST_IDX) begin
               state_d = SCAN_DONE;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         SCAN_PRESENT: begin
            scan_valid = 1'b1;
            if (scan_ack) begin
               w_ack_fire = 1'b1;
               if (ptr_q == LAST_IDX) begin
                  state_d = SCAN_DONE;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = SCAN_SEARCH;
               end
            end
         end
         SCAN_DONE: begin
            scan_done = 1'b1;
            state_d   = SCAN_IDLE;
         end
         default: begin
            state_d = SCAN_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any scan in flight without a done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         dirty_q <= '0;
         state_q <= SCAN_IDLE;
         ptr_q   <= '0;
      end else begin
         dirty_q <= dirty_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign scan_busy  = (state_q != SCAN_IDLE);
   assign scan_index = ptr_q;
   assign any_dirty  = |dirty_q;

   dirty_sel_mux #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .IDX_W      (IDX_W)
   ) u_rd_mux (
      .sel_i  (rd_index),
      .data_i (dirty_q),
      .data_o (rd_dirty)
   );

endmodule : dirty_bit_tracker
`default_nettype wire

// File: tb/tb_dirty_bit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dirty_bit_tracker
// Description : Self-checking bench for dirty_bit_tracker (32, 8 and 64
//               block instances sharing one stimulus bus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dirty_bit_tracker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, clear_all, set_en, clr_en, scan_start, scan_ack;
   logic [7:0] set_idx, clr_idx, rd_idx;

   logic       rd_dirty, any_dirty, scan_busy, scan_valid, scan_done;
   logic [4:0] scan_index;
   logic       rd_dirty8, any_dirty8, scan_busy8, scan_valid8, scan_done8;
   logic [2:0] scan_index8;
   logic       rd_dirty64, any_dirty64, scan_busy64, scan_valid64, scan_done64;
   logic [5:0] scan_index64;

   dirty_bit_tracker #(.NUM_BLOCKS(32)) dut (
      .clk(clk), .reset(reset), .clear_all(clear_all),
      .set_en(set_en), .set_index(set_idx[4:0]),
      .clr_en(clr_en), .clr_index(clr_idx[4:0]),
      .rd_index(rd_idx[4:0]), .rd_dirty(rd_dirty), .any_dirty(any_dirty),
      .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
      .scan_index(scan_index), .scan_ack(scan_ack), .scan_done(scan_done)
   );

   dirty_bit_tracker #(.NUM_BLOCKS(8)) dut8 (
      .clk(clk), .reset(reset), .clear_all(clear_all),
      .set_en(set_en), .set_index(set_idx[2:0]),
      .clr_en(clr_en), .clr_index(clr_idx[2:0]),
      .rd_index(rd_idx[2:0]), .rd_dirty(rd_dirty8), .any_dirty(any_dirty8),
      .scan_start(scan_start), .scan_busy(scan_busy8), .scan_valid(scan_valid8),
      .scan_index(scan_index8), .scan_ack(scan_ack), .scan_done(scan_done8)
   );

   dirty_bit_tracker #(.NUM_BLOCKS(64)) dut64 (
      .clk(clk), .reset(reset), .clear_all(clear_all),
      .set_en(set_en), .set_index(set_idx[5:0]),
      .clr_en(clr_en), .clr_index(clr_idx[5:0]),
      .rd_index(rd_idx[5:0]), .rd_dirty(rd_dirty64), .any_dirty(any_dirty64),
      .scan_start(scan_start), .scan_busy(scan_busy64), .scan_valid(scan_valid64),
      .scan_index(scan_index64), .scan_ack(scan_ack), .scan_done(scan_done64)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic       clr_all;
      logic       set_e;
      logic [7:0] set_i;
      logic       clr_e;
      logic [7:0] clr_i;
      logic [7:0] rd_i;
      logic       exp_pre;
      logic       exp_post;
      logic       exp_any;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic ca, input logic se, input int si,
                               input logic ce, input int ci, input int ri,
                               input logic ep, input logic eo, input logic ea);
      vec_t v;
      v.rst = r; v.clr_all = ca; v.set_e = se; v.set_i = 8'(si);
      v.clr_e = ce; v.clr_i = 8'(ci); v.rd_i = 8'(ri);
      v.exp_pre = ep; v.exp_post = eo; v.exp_any = ea;
      return v;
   endfunction

   vec_t vt [12];

   // scan bookkeeping shared between do_scan and the main sequence
   int   exp_q [$];
   int   n_seen, n_done, first_valid, done_k;
   logic timed_out;

   // mode 0 plain, 1 re-start while busy, 2 set during present/ack, 3 flush while presenting
   task automatic do_scan(input int mode);
      int k;
      int pend;
      pend = 0;
      n_seen = 0; n_done = 0; first_valid = -1; done_k = -1; timed_out = 1'b0;
      scan_start = 1'b1;
      for (k = 1; k <= 200; k++) begin
         tick;
         scan_start = (mode == 1 && k == 4);
         set_en = 1'b0; scan_ack = 1'b0; clear_all = 1'b0;
         if (scan_done === 1'b1) begin
            n_done++;
            if (done_k < 0) done_k = k;
         end
         if (scan_valid === 1'b1) begin
            if (first_valid < 0) first_valid = k;
            if (pend == 0) begin
               if (n_seen < exp_q.size())
                  chk($sformatf("scan_idx_%0d", n_seen), 32'(scan_index), exp_q[n_seen]);
               pend = 1;
               if (mode == 2) begin set_en = 1'b1; set_idx = 8'd2; end
               if (mode == 3) clear_all = 1'b1;
            end else begin
               if (n_seen < exp_q.size())
                  chk($sformatf("scan_idx_hold_%0d", n_seen), 32'(scan_index), exp_q[n_seen]);
               scan_ack = 1'b1;
               pend = 0;
               n_seen++;
               if (mode == 2) begin set_en = 1'b1; set_idx = {3'b000, scan_index}; end
            end
         end
         if (done_k >= 0 && k >= done_k + 2) break;
      end
      timed_out = (k > 200);
      scan_start = 1'b0; scan_ack = 1'b0; set_en = 1'b0; clear_all = 1'b0;
      chk("scan_timeout", 32'(timed_out), 0);
   endtask

   task automatic set_bit(input int idx);
      set_en = 1'b1;
      set_idx = 8'(idx);
      tick;
      set_en = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input int idx, input logic exp);
      rd_idx = 8'(idx);
      #1;
      chk(nm, 32'(rd_dirty), 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      reset = 1'b1; clear_all = 1'b0; set_en = 1'b0; clr_en = 1'b0;
      scan_start = 1'b0; scan_ack = 1'b0;
      set_idx = '0; clr_idx = '0; rd_idx = '0;
      repeat (3) tick;

      // reset state
      rd_chk("rst_rd0", 0, 1'b0);
      rd_chk("rst_rd31", 31, 1'b0);
      chk("rst_any", 32'(any_dirty), 0);
      chk("rst_busy", 32'(scan_busy), 0);
      chk("rst_valid", 32'(scan_valid), 0);
      chk("rst_index", 32'(scan_index), 0);
      chk("rst_done", 32'(scan_done), 0);
      reset = 1'b0;
      tick;

      // rst clr_all set_e set_i clr_e clr_i rd  pre post any
      vt[0]  = mk(0, 0, 0,  0, 0,  0,  0, 0, 0, 0);
      vt[1]  = mk(0, 0, 1,  5, 0,  0,  5, 0, 1, 1);
      vt[2]  = mk(0, 0, 0,  0, 0,  0,  4, 0, 0, 1);
      vt[3]  = mk(0, 0, 1,  9, 1,  9,  9, 0, 1, 1);
      vt[4]  = mk(0, 0, 0,  0, 1,  5,  5, 1, 0, 1);
      vt[5]  = mk(0, 0, 1, 31, 1,  9, 31, 0, 1, 1);
      vt[6]  = mk(0, 0, 0,  0, 0,  0,  9, 0, 0, 1);
      vt[7]  = mk(0, 1, 1,  3, 0,  0,  3, 0, 0, 0);
      vt[8]  = mk(0, 0, 1,  0, 0,  0,  0, 0, 1, 1);
      vt[9]  = mk(1, 0, 1,  6, 0,  0,  0, 1, 0, 0);
      vt[10] = mk(0, 0, 1, 17, 0,  0, 17, 0, 1, 1);
      vt[11] = mk(0, 0, 0,  0, 1, 17, 17, 1, 0, 0);

      for (int i = 0; i < 12; i++) begin
         reset = vt[i].rst; clear_all = vt[i].clr_all;
         set_en = vt[i].set_e; set_idx = vt[i].set_i;
         clr_en = vt[i].clr_e; clr_idx = vt[i].clr_i;
         rd_idx = vt[i].rd_i;
         @(negedge clk);
         chk($sformatf("vec%0d_pre_rd", i), 32'(rd_dirty), 32'(vt[i].exp_pre));
         tick;
         chk($sformatf("vec%0d_rd", i), 32'(rd_dirty), 32'(vt[i].exp_post));
         chk($sformatf("vec%0d_any", i), 32'(any_dirty), 32'(vt[i].exp_any));
      end
      reset = 1'b0; clear_all = 1'b0; set_en = 1'b0; clr_en = 1'b0;

      // three dirty blocks reported in order, each cleared on ack
      set_bit(3); set_bit(17); set_bit(31);
      exp_q = '{3, 17, 31};
      do_scan(0);
      chk("s3_seen", n_seen, 3);
      chk("s3_done", n_done, 1);
      chk("s3_any", 32'(any_dirty), 0);

      // clean array: full sweep, start while busy ignored
      exp_q = '{};
      do_scan(1);
      chk("clean_valid", first_valid, -1);
      chk("clean_done_edge", done_k, 33);
      chk("clean_done_cnt", n_done, 1);

      // block 0 dirty: presented two edges after the start
      set_bit(0);
      exp_q = '{0};
      do_scan(0);
      chk("lat_valid_edge", first_valid, 2);
      chk("lat_done_cnt", n_done, 1);

      // set of presented index in ack cycle loses; set behind the pointer unreported
      set_bit(10);
      exp_q = '{10};
      do_scan(2);
      chk("ackset_seen", n_seen, 1);
      chk("ackset_done", n_done, 1);
      rd_chk("ackset_rd10", 10, 1'b0);
      rd_chk("ackset_rd2", 2, 1'b1);
      clear_all = 1'b1; tick; clear_all = 1'b0;

      // flush while presenting does not abort the scan
      set_bit(4); set_bit(20);
      exp_q = '{4};
      do_scan(3);
      chk("flush_seen", n_seen, 1);
      chk("flush_done", n_done, 1);
      rd_chk("flush_rd20", 20, 1'b0);
      chk("flush_any", 32'(any_dirty), 0);

      // reset while presenting index 7, for 32, 8 and 64 blocks
      reset = 1'b1; tick; reset = 1'b0;
      set_bit(7);
      scan_start = 1'b1; tick; scan_start = 1'b0;
      for (int c = 0; c < 50 && !(scan_valid === 1'b1 && scan_valid8 === 1'b1 && scan_valid64 === 1'b1); c++)
         tick;
      chk("mid_idx32", 32'(scan_index), 7);
      chk("mid_idx8", 32'(scan_index8), 7);
      chk("mid_idx64", 32'(scan_index64), 7);
      reset = 1'b1; tick; reset = 1'b0;
      rd_idx = 8'd7; #1;
      chk("mid_valid32", 32'(scan_valid), 0);
      chk("mid_busy32", 32'(scan_busy), 0);
      chk("mid_any32", 32'(any_dirty), 0);
      chk("mid_rd32", 32'(rd_dirty), 0);
      chk("mid_valid8", 32'(scan_valid8), 0);
      chk("mid_busy8", 32'(scan_busy8), 0);
      chk("mid_any8", 32'(any_dirty8), 0);
      chk("mid_rd8", 32'(rd_dirty8), 0);
      chk("mid_valid64", 32'(scan_valid64), 0);
      chk("mid_busy64", 32'(scan_busy64), 0);
      chk("mid_any64", 32'(any_dirty64), 0);
      chk("mid_rd64", 32'(rd_dirty64), 0);
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         cnt += int'(scan_done) + int'(scan_done8) + int'(scan_done64);
         tick;
      end
      chk("mid_no_done", cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dirty_bit_tracker
`default_nettype wire

// File: doc/dirty_bit_tracker.md
DIRTY_BIT_TRACKER -- requirements
Module: dirty_bit_tracker

Interface
REQ-001 The block SHALL have parameter NUM_BLOCKS, default 32, giving the number of cache blocks tracked (power of two, 2..256).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(NUM_BLOCKS), giving the block index width.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear_all  input  1  clears every dirty bit (cache flush).
REQ-006 set_en / set_index  input  1 / IDX_W  marks a block dirty.
REQ-007 clr_en / clr_index  input  1 / IDX_W  marks a block clean.
REQ-008 rd_index  input  IDX_W  selects the block for query.
REQ-009 rd_dirty  output  1  dirty bit of block rd_index, combinational from the registered array.
REQ-010 any_dirty  output  1  OR of all dirty bits, registered-array based.
REQ-011 scan_start  input  1  request a write-back scan.
REQ-012 scan_busy  output  1  high while the scan FSM is not IDLE.
REQ-013 scan_valid / scan_index  output  1 / IDX_W  a dirty block is presented.
REQ-014 scan_ack  input  1  consumer accepted the presented block.
REQ-015 scan_done  output  1  one-cycle pulse at scan completion.

Function
REQ-016 The dirty array SHALL update with priority: reset > clear_all > scan_ack clear > set_en > clr_en, per index.
REQ-017 When set_en and clr_en target the same index in one cycle, the bit SHALL end set.
REQ-018 rd_dirty SHALL reflect the array value before the current edge (no write bypass).
REQ-019 The scan FSM SHALL have states IDLE, SEARCH, PRESENT, DONE.
REQ-020 In IDLE, scan_start SHALL load ptr=0 and move to SEARCH at the next edge; scan_start in any other state SHALL be ignored.
REQ-021 In SEARCH, one index per cycle SHALL be examined: dirty[ptr]=1 -> PRESENT with scan_index=ptr; else if ptr=NUM_BLOCKS-1 -> DONE; else ptr+1.
REQ-022 In PRESENT, scan_valid SHALL be 1 and scan_index stable until scan_ack.
REQ-023 On scan_ack in PRESENT, dirty[scan_index] SHALL clear, and the FSM SHALL go to DONE if scan_index=NUM_BLOCKS-1, else SEARCH with ptr=scan_index+1.
REQ-024 scan_ack outside PRESENT SHALL have no effect.
REQ-025 DONE SHALL assert scan_done for exactly one cycle, then return to IDLE.
REQ-026 set_en on the presented index in the scan_ack cycle SHALL leave the bit clear (ack wins); a set on an index already passed SHALL not be reported by this scan.
REQ-027 clear_all during a scan SHALL not abort it; the scan continues and finds no further dirty bits.
REQ-028 Latency: scan_start at edge t, dirty[0]=1 -> scan_valid high after edge t+2; clean array -> scan_done high after edge t+NUM_BLOCKS+1.

Reset
REQ-029 Reset SHALL clear all dirty bits, set FSM to IDLE, ptr=0, and drive rd_dirty=0 (for any rd_index), any_dirty=0, scan_busy=0, scan_valid=0, scan_index=0, scan_done=0.
REQ-030 Reset asserted mid-scan SHALL abandon the scan without a scan_done pulse.

Structure
REQ-031 The FSM state encoding and the NUM_BLOCKS default SHALL live in shared package superfx_cache_pkg.
REQ-032 The rd_index selection SHALL be a parametrised sub-module dirty_sel_mux (IDX_W-bit selector, NUM_BLOCKS inputs, 1 output).

Verification
REQ-033 Reset, then set_en index 5 -> next cycle rd_index=5 gives rd_dirty=1, any_dirty=1, rd_index=4 gives 0.
REQ-034 set_en and clr_en both index 9 same cycle -> dirty[9]=1.
REQ-035 Dirty {3,17,31}, scan_start, scan_ack one cycle after each scan_valid -> scan_index 3,17,31 in order, then single scan_done; any_dirty=0.
REQ-036 Clean array, scan_start at t -> no scan_valid, scan_done after edge t+33 (NUM_BLOCKS=32), scan_start during busy ignored.
REQ-037 Dirty {10}, scan presenting 10, set_en 2 and set_en 10 with scan_ack -> dirty[10]=0, dirty[2]=1 unreported, scan_done follows.
REQ-038 Reset asserted while PRESENT index 7 -> next cycle scan_valid=0, scan_busy=0, no scan_done, all bits clear; repeat with NUM_BLOCKS=8 and 64.
